// File: rtl/des_key_loader_if.sv
// Key-load bus for des_key_loader: byte stream in, committed key/mode out.
// master = key source / control side, slave = des_key_loader.
interface des_key_loader_if;
   logic        load_start;
   logic        mode_i;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        key_clear;
   logic        key_in_use;
   logic [63:0] init_key;
   logic        encrypt_decrypt;
   logic        key_valid;
   logic        parity_err;

   modport master (
      output load_start, mode_i, byte_valid, byte_data, key_clear, key_in_use,
      input  byte_ready, init_key, encrypt_decrypt, key_valid, parity_err
   );

   modport slave (
      input  load_start, mode_i, byte_valid, byte_data, key_clear, key_in_use,
      output byte_ready, init_key, encrypt_decrypt, key_valid, parity_err
   );
endinterface

// File: rtl/des_key_loader.sv
// Assembles an 8-byte DES key (MSB first) into a shadow register and commits it with its mode.
// Optional DES odd-parity check on commit is enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_loader (
   input  logic            clk,
   input  logic            rst,
   des_key_loader_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_VALID = 2'd3;

   logic [1:0]  state;
   logic [2:0]  cnt;
   logic [63:0] shadow;
   logic        shadow_mode;
   logic [63:0] init_key;
   logic        encrypt_decrypt;
   logic        key_valid;
   logic        parity_err;
   logic        start_ok;
   logic        byte_xfer;
   logic        check_pass;

`ifdef DES_KEY_PARITY_CHECK_EN
   function automatic logic odd_parity_ok(input logic [63:0] k);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
         ok = ok & (^k[8*i +: 8]);
      end
      return ok;
   endfunction

   assign check_pass = odd_parity_ok(shadow);
`else
   assign check_pass = 1'b1;
`endif

   // Restart is legal from LOAD too; CHECK ignores load_start so a commit cannot be torn.
   assign start_ok  = bus.load_start && !bus.key_in_use &&
                      (state == S_IDLE || state == S_VALID || state == S_LOAD);
   assign byte_xfer = (state == S_LOAD) && bus.byte_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         cnt             <= '0;
         shadow          <= '0;
         shadow_mode     <= 1'b0;
         init_key        <= '0;
         encrypt_decrypt <= 1'b0;
         key_valid       <= 1'b0;
         parity_err      <= 1'b0;
      end else if (bus.key_clear) begin
         state           <= S_IDLE;
         cnt             <= '0;
         shadow          <= '0;
         shadow_mode     <= 1'b0;
         init_key        <= '0;
         encrypt_decrypt <= 1'b0;
         key_valid       <= 1'b0;
         parity_err      <= 1'b0;
      end else if (start_ok) begin
         state       <= S_LOAD;
         cnt         <= '0;
         shadow      <= '0;
         shadow_mode <= bus.mode_i;
         key_valid   <= 1'b0;
         parity_err  <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (byte_xfer) begin
                  shadow[{3'd7 - cnt, 3'b000} +: 8] <= bus.byte_data;
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     state <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               if (check_pass) begin
                  init_key        <= shadow;
                  encrypt_decrypt <= shadow_mode;
                  key_valid       <= 1'b1;
                  state           <= S_VALID;
               end else begin
                  parity_err <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.byte_ready      = (state == S_LOAD);
   assign bus.init_key        = init_key;
   assign bus.encrypt_decrypt = encrypt_decrypt;
   assign bus.key_valid       = key_valid;
   assign bus.parity_err      = parity_err;

endmodule

// File: tb/tb_des_key_loader.sv
// Directed bench for des_key_loader: loads, parity failure, restart, lock, clear and mid-load reset.
module tb_des_key_loader;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   des_key_loader_if bus();

   des_key_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_load(input logic mode);
      bus.load_start = 1'b1;
      bus.mode_i     = mode;
      step();
      bus.load_start = 1'b0;
      bus.mode_i     = 1'b0;
   endtask

   task automatic send_bytes(input logic [63:0] key, input int n);
      for (int i = 0; i < n; i++) begin
         bus.byte_valid = 1'b1;
         bus.byte_data  = key[8*(7-i) +: 8];
         step();
      end
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
   endtask

   logic [63:0] key_a;
   logic [63:0] key_ones;
   logic [63:0] key_zero;

   initial begin
      vectors     = 0;
      miscompares = 0;
      key_a       = 64'h133457799BBCDFF1;
      key_ones    = 64'h0101010101010101;
      key_zero    = 64'h0;
      bus.load_start = 1'b0;
      bus.mode_i     = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      bus.key_clear  = 1'b0;
      bus.key_in_use = 1'b0;
      rst = 1'b1;
      step();
      step();
      chk("rst_ready",   {63'd0, bus.byte_ready},      64'd0);
      chk("rst_valid",   {63'd0, bus.key_valid},       64'd0);
      chk("rst_key",     bus.init_key,                 64'd0);
      chk("rst_ed",      {63'd0, bus.encrypt_decrypt}, 64'd0);
      chk("rst_perr",    {63'd0, bus.parity_err},      64'd0);

      // First load on the first edge after reset release.
      @(negedge clk);
      rst = 1'b0;
      start_load(1'b1);
      chk("a_ready",     {63'd0, bus.byte_ready},      64'd1);
      send_bytes(key_a, 8);
      chk("a_check_rdy", {63'd0, bus.byte_ready},      64'd0);
      chk("a_check_kv",  {63'd0, bus.key_valid},       64'd0);
      step();
      chk("a_kv",        {63'd0, bus.key_valid},       64'd1);
      chk("a_key",       bus.init_key,                 key_a);
      chk("a_ed",        {63'd0, bus.encrypt_decrypt}, 64'd1);
      chk("a_perr",      {63'd0, bus.parity_err},      64'd0);

      // All-zero key: fails odd parity when checking is built in.
      start_load(1'b1);
      chk("z_kv_clr",    {63'd0, bus.key_valid},       64'd0);
      send_bytes(key_zero, 8);
      step();
`ifdef DES_KEY_PARITY_CHECK_EN
      chk("z_perr",      {63'd0, bus.parity_err},      64'd1);
      chk("z_kv",        {63'd0, bus.key_valid},       64'd0);
      chk("z_key",       bus.init_key,                 key_a);
      chk("z_ed",        {63'd0, bus.encrypt_decrypt}, 64'd1);
`else
      chk("z_perr",      {63'd0, bus.parity_err},      64'd0);
      chk("z_kv",        {63'd0, bus.key_valid},       64'd1);
      chk("z_key",       bus.init_key,                 key_zero);
`endif

      // Partial load of three bytes, then restart with decrypt mode.
      start_load(1'b1);
      chk("r_perr_clr",  {63'd0, bus.parity_err},      64'd0);
      send_bytes(64'hAABBCCDDEEFF1122, 3);
      start_load(1'b0);
      chk("r_ready",     {63'd0, bus.byte_ready},      64'd1);
      send_bytes(key_ones, 8);
      step();
      chk("r_kv",        {63'd0, bus.key_valid},       64'd1);
      chk("r_key",       bus.init_key,                 key_ones);
      chk("r_ed",        {63'd0, bus.encrypt_decrypt}, 64'd0);

      // Bytes offered while VALID are dropped.
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'hFF;
      step();
      step();
      bus.byte_valid = 1'b0;
      chk("bv_key",      bus.init_key,                 key_ones);
      chk("bv_ready",    {63'd0, bus.byte_ready},      64'd0);

      // Key locked while in use.
      bus.key_in_use = 1'b1;
      start_load(1'b1);
      chk("lk_ready",    {63'd0, bus.byte_ready},      64'd0);
      chk("lk_kv",       {63'd0, bus.key_valid},       64'd1);
      chk("lk_key",      bus.init_key,                 key_ones);
      step();
      chk("lk_ready2",   {63'd0, bus.byte_ready},      64'd0);
      bus.key_in_use = 1'b0;

      // Clear wins over a simultaneous start.
      bus.key_clear = 1'b1;
      start_load(1'b1);
      bus.key_clear = 1'b0;
      chk("kc_key",      bus.init_key,                 64'd0);
      chk("kc_kv",       {63'd0, bus.key_valid},       64'd0);
      chk("kc_ready",    {63'd0, bus.byte_ready},      64'd0);
      chk("kc_ed",       {63'd0, bus.encrypt_decrypt}, 64'd0);

      // Reset mid-load takes effect without a clock edge.
      start_load(1'b1);
      send_bytes(key_a, 5);
      chk("m_ready",     {63'd0, bus.byte_ready},      64'd1);
      rst = 1'b1;
      #1;
      chk("m_ready_rst", {63'd0, bus.byte_ready},      64'd0);
      chk("m_key_rst",   bus.init_key,                 64'd0);
      chk("m_kv_rst",    {63'd0, bus.key_valid},       64'd0);
      step();
      @(negedge clk);
      rst = 1'b0;
      start_load(1'b1);
      send_bytes(key_a, 8);
      step();
      chk("m_kv",        {63'd0, bus.key_valid},       64'd1);
      chk("m_key",       bus.init_key,                 key_a);
      chk("m_ed",        {63'd0, bus.encrypt_decrypt}, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
